// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the two-stage CPU pipeline sequencer.
// Contents: opcode constants, halt/nop words, instruction field positions
// and the sequencer state encoding.
package pipeline_hazard_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    localparam logic [15:0] NOP_WORD  = 16'h0000;

    localparam int unsigned OP_HI = 15;
    localparam int unsigned OP_LO = 12;
    localparam int unsigned RS_HI = 11;
    localparam int unsigned RS_LO = 10;
    localparam int unsigned RT_HI = 9;
    localparam int unsigned RT_LO = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STALL  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

endpackage

// File: rtl/pipeline_hazard_ctrl_src_reg_decode.sv
// Source-register usage decoder for the IF/ID instruction.
// Ports:
//   op      in  4  opcode field
//   is_halt in  1  instruction is the halt word (reads nothing)
//   uses_rs out 1  instruction reads rs
//   uses_rt out 1  instruction reads rt
module src_reg_decode
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [3:0] op,
    input  logic       is_halt,
    output logic       uses_rs,
    output logic       uses_rt
);

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        if (!is_halt) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_XOR,
                OP_SW, OP_BEQ, OP_BNE: begin
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                end
                OP_ADDI, OP_LW: uses_rs = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 16-bit two-stage (IF/ID -> ID/EX) CPU.
// Decides PC / IF/ID advance, ID/EX bubble insertion and IF/ID flush for
// RAW hazards, taken branches and halt drain; keeps saturating stall and
// flush counters. State updates on the falling clock edge.
// Ports:
//   clock, reset_n                 clock (falling edge), async active-low reset
//   ifid_ir, ifid_valid            instruction in IF/ID and its valid flag
//   idex_valid, idex_regwrite,
//   idex_memtoreg, idex_wr         producer information from ID/EX
//   branch_taken                   branch resolved taken in EX
//   pc_en, ifid_en, ifid_flush,
//   idex_bubble                    pipeline-register controls (combinational)
//   halted                         pipeline stopped until reset
//   stall_cnt, flush_cnt           saturating performance counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned ALU_STALL    = 1,
    parameter int unsigned LOAD_STALL   = 2,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [15:0]      ifid_ir,
    input  logic             ifid_valid,
    input  logic             idex_valid,
    input  logic             idex_regwrite,
    input  logic             idex_memtoreg,
    input  logic [1:0]       idex_wr,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    if (ALU_STALL == 0 || LOAD_STALL == 0 || DRAIN_CYCLES == 0 || CNT_W == 0) begin : g_bad_param
        $error("pipeline_hazard_ctrl: parameters must be non-zero");
    end

    localparam int unsigned MAXP = (ALU_STALL > LOAD_STALL)
                                 ? ((ALU_STALL > DRAIN_CYCLES) ? ALU_STALL : DRAIN_CYCLES)
                                 : ((LOAD_STALL > DRAIN_CYCLES) ? LOAD_STALL : DRAIN_CYCLES);
    localparam int unsigned CW = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] ALU_REM   = CW'(ALU_STALL - 1);
    localparam logic [CW-1:0] LOAD_REM  = CW'(LOAD_STALL - 1);
    localparam logic [CW-1:0] DRAIN_REM = CW'(DRAIN_CYCLES - 1);

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] rem, rem_nxt;
    logic [CW-1:0] stall_rem;
    logic          stall_inc, flush_inc;
    logic          is_halt, uses_rs, uses_rt, hazard, halt_req;
    logic [1:0]    rs, rt;

    assign rs       = ifid_ir[RS_HI:RS_LO];
    assign rt       = ifid_ir[RT_HI:RT_LO];
    assign is_halt  = (ifid_ir == HALT_WORD);
    assign halt_req = ifid_valid & is_halt;

    src_reg_decode u_decode (
        .op      (ifid_ir[OP_HI:OP_LO]),
        .is_halt (is_halt),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign hazard = ifid_valid & idex_valid & idex_regwrite & (idex_wr != 2'd0)
                  & ((uses_rs & (rs == idex_wr)) | (uses_rt & (rt == idex_wr)));

    assign stall_rem = idex_memtoreg ? LOAD_REM : ALU_REM;

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b0;
        state_nxt   = state;
        rem_nxt     = rem;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_RUN;
            ST_RUN: begin
                // A taken branch makes the IF/ID word wrong-path, so its
                // hazard or halt is irrelevant.
                if (branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (hazard) begin
                    stall_inc = 1'b1;
                    if (stall_rem != '0) begin
                        state_nxt = ST_STALL;
                        rem_nxt   = stall_rem;
                    end
                end else if (halt_req) begin
                    if (DRAIN_REM != '0) begin
                        state_nxt = ST_DRAIN;
                        rem_nxt   = DRAIN_REM;
                    end else begin
                        state_nxt = ST_HALTED;
                    end
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_bubble = 1'b0;
                end
            end
            // rem counts the cycles still to be spent here, including this one.
            ST_STALL: begin
                stall_inc = 1'b1;
                rem_nxt   = rem - CW'(1);
                if (rem_nxt == '0) state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                rem_nxt = rem - CW'(1);
                if (rem_nxt == '0) state_nxt = ST_HALTED;
            end
            ST_HALTED: halted = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rem       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl, plus a second
// instance with 2-bit counters to observe saturation.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] ifid_ir;
    logic        ifid_valid, idex_valid, idex_regwrite, idex_memtoreg, branch_taken;
    logic [1:0]  idex_wr;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_en2, ifid_en2, ifid_flush2, idex_bubble2, halted2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl dut (
        .clock(clock), .reset_n(reset_n), .ifid_ir(ifid_ir), .ifid_valid(ifid_valid),
        .idex_valid(idex_valid), .idex_regwrite(idex_regwrite), .idex_memtoreg(idex_memtoreg),
        .idex_wr(idex_wr), .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .ifid_ir(ifid_ir), .ifid_valid(ifid_valid),
        .idex_valid(idex_valid), .idex_regwrite(idex_regwrite), .idex_memtoreg(idex_memtoreg),
        .idex_wr(idex_wr), .branch_taken(branch_taken), .pc_en(pc_en2), .ifid_en(ifid_en2),
        .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .halted(halted2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ifid_ir       = 16'h0000;
        ifid_valid    = 1'b0;
        idex_valid    = 1'b0;
        idex_regwrite = 1'b0;
        idex_memtoreg = 1'b0;
        idex_wr       = 2'd0;
        branch_taken  = 1'b0;
    endtask

    task automatic producer(input logic [1:0] wr, input logic is_load);
        idex_valid    = 1'b1;
        idex_regwrite = 1'b1;
        idex_memtoreg = is_load;
        idex_wr       = wr;
    endtask

    task automatic consumer(input logic [15:0] ir);
        ifid_ir    = ir;
        ifid_valid = 1'b1;
    endtask

    // Advance one falling edge; inputs are then driven 1 time unit later.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        #3;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_ifid_en", ifid_en, 0);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_bubble", idex_bubble, 1);
        chk("rst_halted", halted, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        step();
        chk("rst_hold_pc_en", pc_en, 0);
        reset_n = 1'b1;
        #2;
        chk("idle_pc_en", pc_en, 0);
        chk("idle_bubble", idex_bubble, 1);
        step();
        #2;
        chk("run_pc_en", pc_en, 1);
        chk("run_bubble", idex_bubble, 0);

        // 1: addi $1 in ID/EX, and $3,$1,$2 in IF/ID
        producer(2'd1, 1'b0);
        consumer(16'h26C0);
        #2;
        chk("alu_pc_en", pc_en, 0);
        chk("alu_ifid_en", ifid_en, 0);
        chk("alu_bubble", idex_bubble, 1);
        step();
        idex_valid = 1'b0;
        #2;
        chk("alu_stall_cnt", stall_cnt, 1);
        chk("alu_sat_cnt", stall_cnt2, 1);
        chk("alu_back_pc_en", pc_en, 1);
        chk("alu_back_bubble", idex_bubble, 0);

        // 2: lw $1 in ID/EX, add $3,$1,$2 in IF/ID
        producer(2'd1, 1'b1);
        consumer(16'h06C0);
        #2;
        chk("lw_c1_pc_en", pc_en, 0);
        step();
        idex_valid = 1'b0;
        #2;
        chk("lw_c2_pc_en", pc_en, 0);
        chk("lw_c2_bubble", idex_bubble, 1);
        chk("lw_c2_stall_cnt", stall_cnt, 2);
        step();
        #2;
        chk("lw_back_pc_en", pc_en, 1);
        chk("lw_stall_cnt", stall_cnt, 3);
        chk("lw_sat_cnt", stall_cnt2, 3);

        // 3: no-hazard boundaries
        producer(2'd0, 1'b0);
        consumer(16'h00C0);
        #2;
        chk("r0_pc_en", pc_en, 1);
        step();
        producer(2'd2, 1'b0);
        consumer(16'h7600);
        #2;
        chk("addi_rt_pc_en", pc_en, 1);
        step();
        consumer(16'h8600);
        #2;
        chk("lw_rt_pc_en", pc_en, 1);
        step();
        producer(2'd1, 1'b0);
        consumer(16'h26C0);
        ifid_valid = 1'b0;
        #2;
        chk("ifid_inval_pc_en", pc_en, 1);
        step();
        consumer(16'h26C0);
        idex_regwrite = 1'b0;
        #2;
        chk("noregwr_pc_en", pc_en, 1);
        step();
        chk("nohaz_stall_cnt", stall_cnt, 3);

        // 4: branch with a simultaneous hazard
        producer(2'd1, 1'b0);
        consumer(16'h26C0);
        branch_taken = 1'b1;
        #2;
        chk("br_flush", ifid_flush, 1);
        chk("br_pc_en", pc_en, 1);
        chk("br_bubble", idex_bubble, 1);
        step();
        branch_taken = 1'b0;
        idex_valid   = 1'b0;
        #2;
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 3);
        chk("br_after_flush", ifid_flush, 0);

        // Saturation: ALU hazard held for 4 cycles
        producer(2'd1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        idex_valid = 1'b0;
        #2;
        chk("sat_stall_cnt", stall_cnt, 7);
        chk("sat_stall_cnt2", stall_cnt2, 3);
        chk("sat_flush_cnt2", flush_cnt2, 1);

        // 5: halt word
        consumer(16'hFFFF);
        #2;
        chk("halt_pc_en", pc_en, 0);
        chk("halt_bubble", idex_bubble, 1);
        chk("halt_c0_halted", halted, 0);
        step();
        #2;
        chk("halt_e1_halted", halted, 0);
        chk("halt_e1_pc_en", pc_en, 0);
        step();
        #2;
        chk("halt_e2_halted", halted, 1);
        for (int i = 0; i < 10; i++) begin
            producer(2'd1, 1'b0);
            consumer(16'h26C0);
            branch_taken = i[0];
            step();
            #2;
            chk("halt_hold", halted, 1);
            chk("halt_hold_pc_en", pc_en, 0);
        end
        chk("halt_stall_frz", stall_cnt, 7);
        chk("halt_flush_frz", flush_cnt, 1);

        // 6: reset mid-STALL
        idle_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        producer(2'd1, 1'b1);
        consumer(16'h06C0);
        step();
        #2;
        chk("mid_stall_pc_en", pc_en, 0);
        chk("mid_stall_cnt", stall_cnt, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_pc_en", pc_en, 0);
        chk("arst_bubble", idex_bubble, 1);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        chk("arst_halted", halted, 0);
        idle_inputs();
        #1;
        reset_n = 1'b1;
        #1;
        chk("rel_idle_pc_en", pc_en, 0);
        step();
        #2;
        chk("rel_run_pc_en", pc_en, 1);
        chk("rel_run_bubble", idex_bubble, 0);

        // Halt word discarded by a taken branch
        consumer(16'hFFFF);
        branch_taken = 1'b1;
        #2;
        chk("brhalt_flush", ifid_flush, 1);
        chk("brhalt_pc_en", pc_en, 1);
        step();
        idle_inputs();
        #2;
        chk("brhalt_halted", halted, 0);
        chk("brhalt_run_pc_en", pc_en, 1);
        chk("brhalt_flush_cnt", flush_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
